// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// pending scoreboard for RAW hazard detection in decode.
module regfile_mp_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*XLEN-1:0]  rd_data_o,
    output logic [NRD-1:0]       rd_ready_o,
    input  logic [NWR-1:0]       wr_en_i,
    input  logic [NWR*AW-1:0]    wr_addr_i,
    input  logic [NWR*XLEN-1:0]  wr_data_i,
    input  logic                 iss_en_i,
    input  logic [AW-1:0]        iss_addr_i,
    output logic [NREG-1:0]      pending_o
);

    // Entry 0 is reset to zero and never written, so it folds to a constant.
    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_pend;

    logic [AW-1:0]   w_rd_addr;
    logic [XLEN-1:0] w_rd_data;
    logic            w_rd_hit;

    // Register array write-back; later port index overrides earlier ones.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NWR); k++) begin
                if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] != '0)) begin
                    r_regs[wr_addr_i[k*AW +: AW]] <= wr_data_i[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Scoreboard: write-back clears, issue sets; issue is applied last so it wins.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_pend <= '0;
        end else begin
            for (int k = 0; k < int'(NWR); k++) begin
                if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] != '0)) begin
                    r_pend[wr_addr_i[k*AW +: AW]] <= 1'b0;
                end
            end
            if (iss_en_i && (iss_addr_i != '0)) begin
                r_pend[iss_addr_i] <= 1'b1;
            end
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        rd_data_o  = '0;
        rd_ready_o = '0;
        w_rd_addr  = '0;
        w_rd_data  = '0;
        w_rd_hit   = 1'b0;
        for (int j = 0; j < int'(NRD); j++) begin
            w_rd_addr = rd_addr_i[j*AW +: AW];
            w_rd_data = r_regs[w_rd_addr];
            w_rd_hit  = 1'b0;
            for (int k = 0; k < int'(NWR); k++) begin
                if ((BYPASS != 0) && wr_en_i[k] && (wr_addr_i[k*AW +: AW] == w_rd_addr)) begin
                    w_rd_data = wr_data_i[k*XLEN +: XLEN];
                    w_rd_hit  = 1'b1;
                end
            end
            if (w_rd_addr == '0) begin
                w_rd_data = '0;
                w_rd_hit  = 1'b1;
            end
            rd_data_o[j*XLEN +: XLEN] = w_rd_data;
            rd_ready_o[j]             = w_rd_hit | ~r_pend[w_rd_addr];
        end
    end

    // Registered scoreboard view; bit 0 is never set.
    assign pending_o = r_pend;

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-write, dual-read integer register file in the decode stage.
- Provides NRD combinational read ports, NWR write-back ports and a write-to-read bypass.
- Register 0 is hardwired to zero, and all registers clear on synchronous reset.
- A per-register pending scoreboard lets decode detect RAW hazards on outstanding producers.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; must be a power of two, at least 2.
- AW, 5, address width; equals log2(NREG).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 forwards same-cycle write data to reads; 0 returns array contents only.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  synchronous active-low reset, sampled at posedge clk_i.
- rd_addr_i  in  NRD*AW  read addresses; port j is bits [j*AW +: AW].
- rd_data_o  out  NRD*XLEN  read data, port j is bits [j*XLEN +: XLEN]; combinational.
- rd_ready_o  out  NRD  1 = port j data is valid (no outstanding producer); combinational.
- wr_en_i  in  NWR  write enables.
- wr_addr_i  in  NWR*AW  write addresses.
- wr_data_i  in  NWR*XLEN  write data.
- iss_en_i  in  1  issue strobe: an instruction with destination iss_addr_i was issued.
- iss_addr_i  in  AW  destination of the issued instruction.
- pending_o  out  NREG  scoreboard bit vector; bit 0 is always 0.

Behaviour:
State:
- reg[1..NREG-1], XLEN bits each; reg[0] is not stored and reads as 0.
- pend[1..NREG-1].

Reset:
- rst_n_i=0 at a posedge clears all reg and pend to 0.
- Reset overrides every write and issue in the same cycle.
- After reset: rd_data_o=0 and rd_ready_o=all 1 for every address, unless a bypass is active on a port (see Read).
- Reset asserted mid-stream discards all pending state. No partial update occurs.

Write (posedge, rst_n_i=1):
- For each k with wr_en_i[k]=1 and wr_addr_i[k]!=0: reg[addr] <= wr_data[k].
- Writes to address 0 are dropped and have no scoreboard effect.
- Two or more ports writing the same address in one cycle: the highest port index wins.

Read (combinational, zero latency):
- addr==0 gives 0.
- Otherwise, if BYPASS=1 and some wr_en_i[k] matches addr this cycle, output wr_data of the highest matching k.
- Otherwise output reg[addr].
- A write is visible from the array in the cycle after its posedge. With BYPASS=1 it is visible in the same cycle.

Scoreboard (posedge, rst_n_i=1):
- A write with wr_en_i[k]=1 to addr!=0 clears pend[addr].
- iss_en_i=1 with iss_addr_i!=0 sets pend[iss_addr_i].
- Set and clear on the same address in the same cycle: set wins, because the newer producer is outstanding.
- iss_addr_i=0 is ignored.
- Re-issuing to an already-pending register leaves it pending. There is no counting; one write clears it.

rd_ready_o[j]:
- 1 if addr==0, or pend[addr]==0, or (BYPASS=1 and a same-cycle write matches addr).
- Otherwise 0.

General:
- pending_o reflects registered pend and does not include same-cycle issue.
- No X propagation: all state is initialised by reset. Before the first reset, contents are undefined and the bench must reset first.

Test Plan:
1. Reset then read: hold rst_n_i=0 for 2 cycles, release, read x1..x31 on both ports → rd_data_o=0, rd_ready_o=2'b11, pending_o=0.
2. Write/read with bypass: wr_en_i[0]=1, addr 5, data 0xDEADBEEF, rd_addr port0=5 in the same cycle → rd_data=0xDEADBEEF that cycle (BYPASS=1) and from the array next cycle. With BYPASS=0 → 0 that cycle, 0xDEADBEEF next.
3. x0 protection: write 0x12345678 to addr 0 on both ports, then issue to 0 → rd_data for addr 0 is 0, pending_o[0]=0.
4. Write conflict: port0 writes x7=0x1111 and port1 writes x7=0x2222 in the same cycle → x7 reads 0x2222 next cycle and also through bypass in that cycle.
5. Scoreboard:
   - Issue x9 → pending_o[9]=1 next cycle and rd_ready for x9 =0.
   - Write x9=0xA5 → rd_ready=1 that cycle (bypass), pend cleared next cycle.
   - Issue x9 and write x9 in the same cycle → pend[9] stays 1.
6. Reset mid-operation: pend[3]=1 and x3=0x55, then assert rst_n_i with a simultaneous write to x3 of 0x77 and an issue to x4 → next cycle x3=0, pend=0.
